palette_lut_decoder: RTL and testbench

PALETTE_LUT_DECODER -- requirements
Module: palette_lut_decoder

---
 rtl/palette_lut_decoder.sv | 156 +++++++++++++++
 tb/tb_palette_lut_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_decoder.sv
// Palette look-up pixel decoder: runtime-writable colour table feeding a
// two-stage pixel pipeline with transparency, out-of-range and per-channel fade.
module palette_lut_decoder #(
  parameter int               IDX_W     = 4,
  parameter int               DEPTH     = 16,
  parameter int               RGB_W     = 12,
  parameter int               TRANS_IDX = 0,
  parameter logic [RGB_W-1:0] ERR_RGB   = RGB_W'(12'hF0F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  input  logic             pix_valid_in,
  input  logic [IDX_W-1:0] pix_index,
  input  logic [1:0]       fade_level,
  output logic             pix_valid_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             transparent_out,
  output logic             err_out
);

  localparam int               CH_W    = RGB_W / 3;
  localparam logic [IDX_W-1:0] TRANS_I = IDX_W'(TRANS_IDX);

  // Power-up palette; entries beyond the built-in set show the error colour.
  function automatic logic [RGB_W-1:0] reset_entry(input logic [31:0] idx);
    logic [RGB_W-1:0] r;
    case (idx)
      32'd0:   r = RGB_W'(12'h000);
      32'd1:   r = RGB_W'(12'hD42);
      32'd2:   r = RGB_W'(12'h921);
      32'd3:   r = RGB_W'(12'hFF9);
      32'd4:   r = RGB_W'(12'h210);
      32'd5:   r = RGB_W'(12'h778);
      32'd6:   r = RGB_W'(12'h6B4);
      32'd7:   r = RGB_W'(12'hDD0);
      32'd8:   r = RGB_W'(12'hFFF);
      32'd9:   r = RGB_W'(12'h0F0);
      32'd10:  r = RGB_W'(12'hBBB);
      default: r = ERR_RGB;
    endcase
    return r;
  endfunction

  // Each channel shifts on its own so no bits borrow across field boundaries.
  function automatic logic [RGB_W-1:0] fade_rgb(input logic [RGB_W-1:0] c,
                                                input logic [1:0]       sh);
    logic [RGB_W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      r[ch*CH_W +: CH_W] = c[ch*CH_W +: CH_W] >> sh;
    end
    return r;
  endfunction

  logic [RGB_W-1:0] pal_q [DEPTH];
  logic [RGB_W-1:0] pal_d [DEPTH];

  logic             s1_valid_q, s1_valid_d;
  logic             s1_trans_q, s1_trans_d;
  logic             s1_err_q,   s1_err_d;
  logic [RGB_W-1:0] s1_rgb_q,   s1_rgb_d;
  logic [1:0]       s1_fade_q,  s1_fade_d;

  logic             out_valid_q, out_valid_d;
  logic             out_trans_q, out_trans_d;
  logic             out_err_q,   out_err_d;
  logic [RGB_W-1:0] out_rgb_q,   out_rgb_d;

  logic             in_range_s;

  // Palette write port; addresses at or above DEPTH never match an entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == IDX_W'(i))) begin
        pal_d[i] = wr_data;
      end else begin
        pal_d[i] = pal_q[i];
      end
    end
  end

  // Stage 1: classify the index and read the pre-write palette contents.
  always_comb begin
    in_range_s = (32'(pix_index) < 32'(DEPTH));
    s1_valid_d = pix_valid_in;
    s1_fade_d  = fade_level;
    s1_trans_d = pix_valid_in && (pix_index == TRANS_I);
    s1_err_d   = pix_valid_in && (pix_index != TRANS_I) && !in_range_s;
    s1_rgb_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pix_index == IDX_W'(i)) begin
        s1_rgb_d = pal_q[i];
      end else begin
        s1_rgb_d = s1_rgb_d;
      end
    end
  end

  // Stage 2: select transparent / error / faded colour; idle slots read as zero.
  always_comb begin
    out_valid_d = s1_valid_q;
    out_trans_d = 1'b0;
    out_err_d   = 1'b0;
    out_rgb_d   = '0;
    if (!s1_valid_q) begin
      out_rgb_d = '0;
    end else if (s1_trans_q) begin
      out_trans_d = 1'b1;
    end else if (s1_err_q) begin
      out_err_d = 1'b1;
      out_rgb_d = ERR_RGB;
    end else begin
      out_rgb_d = fade_rgb(s1_rgb_q, s1_fade_q);
    end
  end

  // State update; reset clears the pipeline and reloads the palette, beating any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_trans_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_rgb_q    <= '0;
      s1_fade_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_trans_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rgb_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pal_q[i] <= reset_entry(32'(i));
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_trans_q  <= s1_trans_d;
      s1_err_q    <= s1_err_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_fade_q   <= s1_fade_d;
      out_valid_q <= out_valid_d;
      out_trans_q <= out_trans_d;
      out_err_q   <= out_err_d;
      out_rgb_q   <= out_rgb_d;
      for (int i = 0; i < DEPTH; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  assign pix_valid_out   = out_valid_q;
  assign rgb_out         = out_rgb_q;
  assign transparent_out = out_trans_q;
  assign err_out         = out_err_q;

endmodule

// File: tb/tb_palette_lut_decoder.sv
// Directed bench for palette_lut_decoder: a full-depth instance and a DEPTH=12
// instance share the same stimulus; each output record is {valid, rgb, trans, err}.
module tb_palette_lut_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [11:0] wr_data = 12'h000;
  logic        pix_valid_in = 1'b0;
  logic [3:0]  pix_index = 4'd0;
  logic [1:0]  fade_level = 2'd0;

  logic        a_valid, a_trans, a_err;
  logic [11:0] a_rgb;
  logic        b_valid, b_trans, b_err;
  logic [11:0] b_rgb;
  logic [14:0] got_a, got_b;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] def_pal [16];

  always #5 clk = ~clk;

  palette_lut_decoder u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index), .fade_level(fade_level),
    .pix_valid_out(a_valid), .rgb_out(a_rgb), .transparent_out(a_trans), .err_out(a_err)
  );

  palette_lut_decoder #(.DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index), .fade_level(fade_level),
    .pix_valid_out(b_valid), .rgb_out(b_rgb), .transparent_out(b_trans), .err_out(b_err)
  );

  assign got_a = {a_valid, a_rgb, a_trans, a_err};
  assign got_b = {b_valid, b_rgb, b_trans, b_err};

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 12'h123;
    pix_valid_in = 1'b1; pix_index = 4'd3; fade_level = 2'd0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (got_a !== 15'h0) begin n_bad++; $display("FAIL reset_a got %h exp %h", got_a, 15'h0); end
    n_cmp++;
    if (got_b !== 15'h0) begin n_bad++; $display("FAIL reset_b got %h exp %h", got_b, 15'h0); end
    rst = 1'b0; wr_en = 1'b0; pix_valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (got_a !== 15'h0) begin n_bad++; $display("FAIL reset_release got %h exp %h", got_a, 15'h0); end
  endtask

  task automatic test_reset_palette();
    logic [14:0] ea, eb;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int j;
        j = k - 2;
        ea = {1'b1, def_pal[j], (j == 0), 1'b0};
        if (j >= 12) eb = {1'b1, 12'hF0F, 1'b0, 1'b1};
        else         eb = {1'b1, def_pal[j], (j == 0), 1'b0};
        n_cmp++;
        if (got_a !== ea) begin n_bad++; $display("FAIL palette_a idx%0d got %h exp %h", j, got_a, ea); end
        n_cmp++;
        if (got_b !== eb) begin n_bad++; $display("FAIL palette_b idx%0d got %h exp %h", j, got_b, eb); end
      end
      pix_valid_in = (k < 16);
      pix_index    = 4'(k);
      fade_level   = 2'd0;
    end
    pix_valid_in = 1'b0;
  endtask

  task automatic test_fade();
    logic [3:0]  idx [7];
    logic [1:0]  fd  [7];
    logic [14:0] ea  [7];
    logic [14:0] eb  [7];
    idx = '{4'd3, 4'd3, 4'd8, 4'd5, 4'd0, 4'd11, 4'd13};
    fd  = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1,  2'd3};
    ea  = '{{1'b1, 12'h774, 2'b00}, {1'b1, 12'h111, 2'b00}, {1'b1, 12'h333, 2'b00},
            {1'b1, 12'h112, 2'b00}, {1'b1, 12'h000, 2'b10}, {1'b1, 12'h707, 2'b00},
            {1'b1, 12'h101, 2'b00}};
    eb  = '{{1'b1, 12'h774, 2'b00}, {1'b1, 12'h111, 2'b00}, {1'b1, 12'h333, 2'b00},
            {1'b1, 12'h112, 2'b00}, {1'b1, 12'h000, 2'b10}, {1'b1, 12'h707, 2'b00},
            {1'b1, 12'hF0F, 2'b01}};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_cmp++;
        if (got_a !== ea[k-2]) begin n_bad++; $display("FAIL fade_a vec%0d got %h exp %h", k-2, got_a, ea[k-2]); end
        n_cmp++;
        if (got_b !== eb[k-2]) begin n_bad++; $display("FAIL fade_b vec%0d got %h exp %h", k-2, got_b, eb[k-2]); end
      end
      if (k < 7) begin
        pix_valid_in = 1'b1; pix_index = idx[k]; fade_level = fd[k];
      end else begin
        pix_valid_in = 1'b0; pix_index = 4'd0; fade_level = 2'd0;
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [14:0] ea, eb;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 12'h5A5;
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int j;
        j = k - 2;
        if (j == 14) ea = {1'b1, 12'h5A5, 2'b00};
        else         ea = {1'b1, def_pal[j], (j == 0), 1'b0};
        if (j >= 12) eb = {1'b1, 12'hF0F, 1'b0, 1'b1};
        else         eb = {1'b1, def_pal[j], (j == 0), 1'b0};
        n_cmp++;
        if (got_a !== ea) begin n_bad++; $display("FAIL oor_a idx%0d got %h exp %h", j, got_a, ea); end
        n_cmp++;
        if (got_b !== eb) begin n_bad++; $display("FAIL oor_b idx%0d got %h exp %h", j, got_b, eb); end
      end
      pix_valid_in = (k < 16);
      pix_index    = 4'(k);
      fade_level   = 2'd0;
    end
    pix_valid_in = 1'b0;
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 12'h123;
    pix_valid_in = 1'b1; pix_index = 4'd5; fade_level = 2'd0;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    pix_valid_in = 1'b0;
    n_cmp++;
    if (got_a !== {1'b1, 12'h778, 2'b00}) begin n_bad++; $display("FAIL collision_old_a got %h exp %h", got_a, {1'b1, 12'h778, 2'b00}); end
    n_cmp++;
    if (got_b !== {1'b1, 12'h778, 2'b00}) begin n_bad++; $display("FAIL collision_old_b got %h exp %h", got_b, {1'b1, 12'h778, 2'b00}); end
    @(negedge clk);
    n_cmp++;
    if (got_a !== {1'b1, 12'h123, 2'b00}) begin n_bad++; $display("FAIL collision_new_a got %h exp %h", got_a, {1'b1, 12'h123, 2'b00}); end
    n_cmp++;
    if (got_b !== {1'b1, 12'h123, 2'b00}) begin n_bad++; $display("FAIL collision_new_b got %h exp %h", got_b, {1'b1, 12'h123, 2'b00}); end
    @(negedge clk);
    n_cmp++;
    if (got_a !== 15'h0) begin n_bad++; $display("FAIL collision_idle got %h exp %h", got_a, 15'h0); end
  endtask

  task automatic test_reset_midstream();
    logic [14:0] e;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int j;
        j = k - 2;
        if (j == 3 || j == 4) e = 15'h0;
        else if (j < 3)       e = {1'b1, 12'h123, 2'b00};
        else                  e = {1'b1, 12'h778, 2'b00};
        n_cmp++;
        if (got_a !== e) begin n_bad++; $display("FAIL midrst_a pix%0d got %h exp %h", j, got_a, e); end
        n_cmp++;
        if (got_b !== e) begin n_bad++; $display("FAIL midrst_b pix%0d got %h exp %h", j, got_b, e); end
      end
      rst          = (k == 4);
      pix_valid_in = (k < 10);
      pix_index    = 4'd5;
      fade_level   = 2'd0;
    end
    rst = 1'b0;
    pix_valid_in = 1'b0;
  endtask

  initial begin
    def_pal = '{12'h000, 12'hD42, 12'h921, 12'hFF9, 12'h210, 12'h778, 12'h6B4, 12'hDD0,
                12'hFFF, 12'h0F0, 12'hBBB, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F};
    test_reset();
    test_reset_palette();
    test_fade();
    test_out_of_range();
    test_collision();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
